// File: rtl/ex_case_seq_gen.sv
// Programmable-length beat generator on a valid/ready stream.
// Supports case-selected patterns, one-shot or looping passes, inter-beat gaps and a graceful stop.
module ex_case_seq_gen #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 8,
  parameter int GAP     = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_mode,
  input  logic [1:0]        i_pat_sel,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_ready,
  output logic              o_dv,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_wrap,
  output logic              o_done
);

  localparam int KW = $clog2(SEQ_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(SEQ_LEN - 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] G_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAPW, S_DONE} state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [DATA_W-1:0] r_walk;
  logic              r_mode;
  logic [1:0]        r_pat;
  logic [DATA_W-1:0] r_seed;
  logic [GW-1:0]     r_gapCnt;
  logic              r_dv;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_wrap;
  logic              r_done;

  logic              w_xfer;
  logic              w_last;
  logic [KW-1:0]     w_kNext;
  logic [DATA_W-1:0] w_walkNext;
  logic [DATA_W-1:0] w_nextBeat;
  logic [DATA_W-1:0] w_gapBeat;
  logic [DATA_W-1:0] w_startBeat;

  // The walking-one value is carried in r_walk so no modulo on k is needed.
  function automatic logic [DATA_W-1:0] f_beat(
    input logic [1:0]        pat,
    input logic [DATA_W-1:0] seed,
    input logic [KW-1:0]     k,
    input logic [DATA_W-1:0] walk
  );
    case (pat)
      2'd0:    return seed + DATA_W'(k);
      2'd1:    return walk;
      2'd2:    return k[0] ? ~seed : seed;
      default: return seed;
    endcase
  endfunction

  assign w_xfer      = r_dv & i_ready;
  assign w_last      = (r_k == K_LAST);
  assign w_kNext     = w_last ? '0 : r_k + KW'(1);
  assign w_walkNext  = w_last ? DATA_W'(1) : {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
  assign w_nextBeat  = f_beat(r_pat, r_seed, w_kNext, w_walkNext);
  assign w_gapBeat   = f_beat(r_pat, r_seed, r_k, r_walk);
  assign w_startBeat = f_beat(i_pat_sel, i_seed, '0, DATA_W'(1));

  // k and the walk register advance at the transfer, so after a gap the
  // pending beat is rebuilt from the already-advanced index.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_walk   <= '0;
      r_mode   <= 1'b0;
      r_pat    <= 2'd0;
      r_seed   <= '0;
      r_gapCnt <= '0;
      r_dv     <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state <= S_SEND;
            r_mode  <= i_mode;
            r_pat   <= i_pat_sel;
            r_seed  <= i_seed;
            r_k     <= '0;
            r_walk  <= DATA_W'(1);
            r_dv    <= 1'b1;
            r_data  <= w_startBeat;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_k    <= w_kNext;
            r_walk <= w_walkNext;
            r_wrap <= w_last;
            if (i_stop || (w_last && !r_mode)) begin
              r_state <= S_DONE;
              r_dv    <= 1'b0;
              r_done  <= 1'b1;
            end else if (GAP > 0) begin
              r_state  <= S_GAPW;
              r_dv     <= 1'b0;
              r_gapCnt <= '0;
            end else begin
              r_data <= w_nextBeat;
            end
          end
        end
        S_GAPW: begin
          if (i_stop) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_gapCnt == G_LAST) begin
            r_state <= S_SEND;
            r_dv    <= 1'b1;
            r_data  <= w_gapBeat;
          end else begin
            r_gapCnt <= r_gapCnt + GW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_dv    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dv   = r_dv;
  assign o_data = r_data;
  assign o_busy = r_busy;
  assign o_wrap = r_wrap;
  assign o_done = r_done;

endmodule

// File: tb/tb_ex_case_seq_gen.sv
// Bench for ex_case_seq_gen: a gap-free instance and a GAP=2 instance, both with four-beat passes.
// Expected beats are queued when a start is driven and compared as each beat is accepted.
module tb_ex_case_seq_gen;

  logic       sclk = 1'b0;
  logic       rst;
  logic       start0, start1, stop, mode, ready;
  logic [1:0] pat;
  logic [7:0] seed;
  logic       dv0, busy0, wrap0, done0;
  logic       dv1, busy1, wrap1, done1;
  logic [7:0] data0, data1;
  logic       sel;
  logic       mDv, mBusy, mWrap, mDone;
  logic [7:0] mData;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic            sel;
    logic [1:0]      pat;
    logic [7:0]      seed;
    int              stallAt;
    int              stallLen;
    int              startAt;
    logic [7:0][7:0] beats;
  } vec_t;

  vec_t vecs[8];

  always #5 sclk = ~sclk;

  ex_case_seq_gen #(.DATA_W(8), .SEQ_LEN(4), .GAP(0)) dut0 (
    .sclk(sclk), .rst(rst), .i_start(start0), .i_stop(stop), .i_mode(mode),
    .i_pat_sel(pat), .i_seed(seed), .i_ready(ready),
    .o_dv(dv0), .o_data(data0), .o_busy(busy0), .o_wrap(wrap0), .o_done(done0)
  );

  ex_case_seq_gen #(.DATA_W(8), .SEQ_LEN(4), .GAP(2)) dut1 (
    .sclk(sclk), .rst(rst), .i_start(start1), .i_stop(stop), .i_mode(mode),
    .i_pat_sel(pat), .i_seed(seed), .i_ready(ready),
    .o_dv(dv1), .o_data(data1), .o_busy(busy1), .o_wrap(wrap1), .o_done(done1)
  );

  assign mDv   = sel ? dv1   : dv0;
  assign mData = sel ? data1 : data0;
  assign mBusy = sel ? busy1 : busy0;
  assign mWrap = sel ? wrap1 : wrap0;
  assign mDone = sel ? done1 : done0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 32'(act), 32'(exp));
  endtask

  // Called on a falling edge; returns on the falling edge where beat 0 should be valid.
  task automatic applyStimulus(input logic s, input logic m, input logic [1:0] p, input logic [7:0] sd,
                               input logic [7:0][7:0] beats, input int n);
    sel   = s;
    mode  = m;
    pat   = p;
    seed  = sd;
    ready = 1'b1;
    stop  = 1'b0;
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(beats[i]);
    if (s) start1 = 1'b1;
    else   start0 = 1'b1;
    @(negedge sclk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // ready/stop/start are decided first because they steer the coming edge;
  // a beat seen valid with ready driven high is the one accepted on that edge.
  task automatic runMonitor(input string name, input int stallAt, input int stallLen, input int startAt,
                            input int stopAt, input int gap, input bit checkSpan);
    int         popped = 0;
    int         cyc = 0;
    int         stallLeft = stallLen;
    int         t0 = 0;
    int         t3 = 0;
    logic       prevHold = 1'b0;
    logic       prevLast = 1'b0;
    logic [7:0] prevData = 8'h00;
    logic [7:0] e;
    checkBit({name, "_latency"}, mDv, 1'b1);
    while (sb.size() > 0 && cyc < 200) begin
      if (prevHold) begin
        checkBit({name, "_hold_dv"}, mDv, 1'b1);
        checkOutput({name, "_hold_data"}, 32'(mData), 32'(prevData));
      end
      checkBit({name, "_wrap"}, mWrap, prevLast);
      checkBit({name, "_done_low"}, mDone, 1'b0);
      checkBit({name, "_busy"}, mBusy, 1'b1);
      ready = !(popped == stallAt && stallLeft > 0 && mDv);
      if (!ready) stallLeft--;
      stop = (popped == stopAt);
      if (popped == startAt) begin
        seed = 8'hFF;
        pat  = 2'd1;
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      prevLast = 1'b0;
      if (mDv && ready) begin
        e = sb.pop_front();
        checkOutput({name, "_data"}, 32'(mData), 32'(e));
        if (popped == 0) t0 = cyc;
        if (popped == 3) t3 = cyc;
        prevLast = (popped % 4 == 3);
        popped++;
      end
      prevHold = mDv && !ready;
      prevData = mData;
      @(negedge sclk);
      cyc++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    stop   = 1'b0;
    ready  = 1'b1;
    checkOutput({name, "_beats_left"}, 32'(sb.size()), 32'd0);
    if (checkSpan) checkOutput({name, "_span"}, 32'(t3 - t0), 32'(3 * (1 + gap) + stallLen));
    checkBit({name, "_done_pulse"}, mDone, 1'b1);
    checkBit({name, "_wrap_end"}, mWrap, prevLast);
    checkBit({name, "_dv_end"}, mDv, 1'b0);
    checkBit({name, "_busy_done"}, mBusy, 1'b1);
    @(negedge sclk);
    checkBit({name, "_busy_idle"}, mBusy, 1'b0);
    checkBit({name, "_done_once"}, mDone, 1'b0);
    checkBit({name, "_wrap_once"}, mWrap, 1'b0);
    checkBit({name, "_dv_idle"}, mDv, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stop = 1'b0; mode = 1'b0;
    pat = 2'd0; seed = 8'h00; ready = 1'b1; sel = 1'b0;

    vecs[0] = '{1'b0, 2'd0, 8'h10, -1, 0, -1, {32'h0, 8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[1] = '{1'b0, 2'd0, 8'h10,  1, 3, -1, {32'h0, 8'h13, 8'h12, 8'h11, 8'h10}};
    vecs[2] = '{1'b1, 2'd1, 8'h00, -1, 0, -1, {32'h0, 8'h08, 8'h04, 8'h02, 8'h01}};
    vecs[3] = '{1'b0, 2'd3, 8'h3C, -1, 0,  1, {32'h0, 8'h3C, 8'h3C, 8'h3C, 8'h3C}};
    vecs[4] = '{1'b0, 2'd0, 8'hFE, -1, 0, -1, {32'h0, 8'h01, 8'h00, 8'hFF, 8'hFE}};
    vecs[5] = '{1'b0, 2'd2, 8'hA5, -1, 0, -1, {32'h0, 8'h5A, 8'hA5, 8'h5A, 8'hA5}};
    vecs[6] = '{1'b1, 2'd2, 8'h0F,  2, 2, -1, {32'h0, 8'hF0, 8'h0F, 8'hF0, 8'h0F}};
    vecs[7] = '{1'b0, 2'd1, 8'h77, -1, 0,  2, {32'h0, 8'h08, 8'h04, 8'h02, 8'h01}};

    repeat (2) @(negedge sclk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkBit("reset_dv", mDv, 1'b0);
      checkOutput("reset_data", 32'(mData), 32'd0);
      checkBit("reset_busy", mBusy, 1'b0);
      checkBit("reset_wrap", mWrap, 1'b0);
      checkBit("reset_done", mDone, 1'b0);
    end
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].sel, 1'b0, vecs[v].pat, vecs[v].seed, vecs[v].beats, 4);
      runMonitor($sformatf("vec%0d", v), vecs[v].stallAt, vecs[v].stallLen, vecs[v].startAt, -1,
                 vecs[v].sel ? 2 : 0, 1'b1);
      @(negedge sclk);
    end

    // Looping pattern 2, stopped while beat 2 of the second pass is accepted.
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h55,
                  {8'h00, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55}, 7);
    runMonitor("loop_stop", -1, 0, -1, 6, 0, 1'b0);
    @(negedge sclk);

    // Start together with stop must not launch anything.
    sel = 1'b0; start0 = 1'b1; stop = 1'b1;
    @(negedge sclk);
    start0 = 1'b0; stop = 1'b0;
    checkBit("startstop_busy", mBusy, 1'b0);
    checkBit("startstop_dv", mDv, 1'b0);
    @(negedge sclk);
    checkBit("startstop_busy2", mBusy, 1'b0);
    checkBit("startstop_dv2", mDv, 1'b0);

    // Reset asserted while beat 2 is on the bus.
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h20, '0, 0);
    checkOutput("rst_beat0", 32'(mData), 32'h20);
    @(negedge sclk);
    checkOutput("rst_beat1", 32'(mData), 32'h21);
    @(negedge sclk);
    checkOutput("rst_beat2", 32'(mData), 32'h22);
    #2 rst = 1'b1;
    #1;
    checkBit("rst_async_dv", mDv, 1'b0);
    checkOutput("rst_async_data", 32'(mData), 32'd0);
    checkBit("rst_async_busy", mBusy, 1'b0);
    checkBit("rst_async_wrap", mWrap, 1'b0);
    checkBit("rst_async_done", mDone, 1'b0);
    @(negedge sclk);
    checkBit("rst_hold_done", mDone, 1'b0);
    rst = 1'b0;
    @(negedge sclk);
    checkBit("rst_after_done", mDone, 1'b0);
    checkBit("rst_after_busy", mBusy, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h20, {32'h0, 8'h23, 8'h22, 8'h21, 8'h20}, 4);
    runMonitor("rst_restart", -1, 0, -1, -1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
